// File: rtl/dma_queue_pkg.sv
// dma_queue_pkg: register word addresses and CTRL/STATUS/IRQ bit positions for dma_queue_controller
package dma_queue_pkg;
  localparam int unsigned A_CTRL       = 0;
  localparam int unsigned A_STATUS     = 1;
  localparam int unsigned A_MM2S_ADDR  = 2;
  localparam int unsigned A_MM2S_BYTES = 3;
  localparam int unsigned A_MM2S_TUSER = 4;
  localparam int unsigned A_S2MM_ADDR  = 5;
  localparam int unsigned A_S2MM_BYTES = 6;
  localparam int unsigned A_MM2S_DONE  = 7;
  localparam int unsigned A_S2MM_DONE  = 8;
  localparam int unsigned A_ERR        = 9;
  localparam int unsigned A_IRQ_PEND   = 10;
  localparam int unsigned A_IRQ_MASK   = 11;
  localparam int unsigned CTRL_PUSH    = 0;
  localparam int unsigned CTRL_CLR     = 1;
  localparam int unsigned ST_MEMPTY    = 0;
  localparam int unsigned ST_MFULL     = 1;
  localparam int unsigned ST_SEMPTY    = 2;
  localparam int unsigned ST_SFULL     = 3;
  localparam int unsigned ST_OVF       = 4;
  localparam int unsigned ST_MERR      = 5;
  localparam int unsigned ST_SERR      = 6;
  localparam int unsigned ST_MLVL      = 8;
  localparam int unsigned ST_SLVL      = 16;
  localparam int unsigned IRQ_MDONE    = 0;
  localparam int unsigned IRQ_SDONE    = 1;
  localparam int unsigned IRQ_ERR      = 2;
endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: DEPTH x WIDTH sync FIFO (clk, rstn_i, push_i/pop_i/din_i in; dout_o head, full_o, empty_o, level_o out)
module dma_desc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] lvl_q;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  assign full_o = lvl_q == (AW+1)'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dma_queue_controller.sv
// dma_queue_controller: paired MM2S/S2MM descriptor queues behind a register port (reg_* in, reg_rd_data out), datamover cmd (desc/user/tag/valid out, ready in) and status (error/valid in); irq output only with DMA_QUEUE_IRQ_EN
module dma_queue_controller
  import dma_queue_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int AXI_TAG_WIDTH   = 8,
  parameter int AXIS_USER_WIDTH = 65,
  parameter int QDEPTH          = 4
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    reg_wr_en,
  input  logic                                    reg_rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0]               reg_wr_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]               reg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]               reg_wr_data,
  output logic [AXI_DATA_WIDTH-1:0]               reg_rd_data,
  output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] mm2s_desc,
  output logic [AXIS_USER_WIDTH-1:0]              mm2s_user,
  output logic                                    mm2s_valid,
  input  logic                                    mm2s_ready,
  input  logic [3:0]                              mm2s_status_error,
  input  logic                                    mm2s_status_valid,
  output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] s2mm_desc,
  output logic [AXI_TAG_WIDTH-1:0]                s2mm_tag,
  output logic                                    s2mm_valid,
  input  logic                                    s2mm_ready,
  input  logic [3:0]                              s2mm_status_error,
  input  logic                                    s2mm_status_valid
`ifdef DMA_QUEUE_IRQ_EN
  ,
  output logic                                    irq
`endif
);
  localparam int DESC_WIDTH = AXI_ADDR_WIDTH + AXI_LEN_WIDTH;
  localparam int LVL_W = $clog2(QDEPTH) + 1;
  localparam int MW = DESC_WIDTH + AXIS_USER_WIDTH;
  localparam int SW = DESC_WIDTH + AXI_TAG_WIDTH;
  logic [AXI_DATA_WIDTH-1:0] m_addr_q, m_bytes_q, m_tuser_q, s_addr_q, s_bytes_q;
  logic [AXI_DATA_WIDTH-1:0] m_cnt_q, m_cnt_d, s_cnt_q, s_cnt_d, rd_data_q, rd_d, status, w1c;
  logic [AXI_TAG_WIDTH-1:0] seq_q;
  logic [7:0] err_q, err_d;
  logic ovf_q, ovf_d, m_err_q, m_err_d, s_err_q, s_err_d;
  logic push, clr, push_ok, ovf_ev, m_full, m_empty, s_full, s_empty, m_done, s_done, m_fail, s_fail;
  logic [LVL_W-1:0] m_lvl, s_lvl;
  logic [MW-1:0] m_dout;
  logic [SW-1:0] s_dout;
`ifdef DMA_QUEUE_IRQ_EN
  logic [2:0] pend_q, pend_d;
  logic [AXI_DATA_WIDTH-1:0] mask_q;
  logic irq_q;
`endif
  function automatic logic wr_hit(input int unsigned a);
    return reg_wr_en && reg_wr_addr == AXI_ADDR_WIDTH'(a);
  endfunction
  assign push = wr_hit(A_CTRL) && reg_wr_data[CTRL_PUSH];
  assign clr = wr_hit(A_CTRL) && reg_wr_data[CTRL_CLR];
  // Both queues accept or both refuse, so MM2S/S2MM entries stay paired
  assign push_ok = push && !m_full && !s_full;
  assign ovf_ev = push && !push_ok;
  assign w1c = wr_hit(A_STATUS) ? reg_wr_data : '0;
  assign m_done = mm2s_status_valid && mm2s_status_error == 4'd0;
  assign m_fail = mm2s_status_valid && mm2s_status_error != 4'd0;
  assign s_done = s2mm_status_valid && s2mm_status_error == 4'd0;
  assign s_fail = s2mm_status_valid && s2mm_status_error != 4'd0;
  assign mm2s_valid = !m_empty;
  assign s2mm_valid = !s_empty;
  assign mm2s_desc = m_dout[DESC_WIDTH-1:0];
  assign mm2s_user = m_dout[MW-1:DESC_WIDTH];
  assign s2mm_desc = s_dout[DESC_WIDTH-1:0];
  assign s2mm_tag = s_dout[SW-1:DESC_WIDTH];
  assign reg_rd_data = rd_data_q;
  dma_desc_fifo #(.WIDTH(MW), .DEPTH(QDEPTH)) u_mm2s_fifo (
    .clk(clk), .rstn_i(rstn), .push_i(push_ok), .pop_i(mm2s_valid && mm2s_ready),
    .din_i({AXIS_USER_WIDTH'(m_tuser_q), AXI_LEN_WIDTH'(m_bytes_q), AXI_ADDR_WIDTH'(m_addr_q)}),
    .dout_o(m_dout), .full_o(m_full), .empty_o(m_empty), .level_o(m_lvl)
  );
  dma_desc_fifo #(.WIDTH(SW), .DEPTH(QDEPTH)) u_s2mm_fifo (
    .clk(clk), .rstn_i(rstn), .push_i(push_ok), .pop_i(s2mm_valid && s2mm_ready),
    .din_i({seq_q, AXI_LEN_WIDTH'(s_bytes_q), AXI_ADDR_WIDTH'(s_addr_q)}),
    .dout_o(s_dout), .full_o(s_full), .empty_o(s_empty), .level_o(s_lvl)
  );
  // Sticky bits: a set event in the same cycle as W1C wins
  always_comb begin
    ovf_d = ovf_ev || (ovf_q && !w1c[ST_OVF]);
    m_err_d = m_fail || (m_err_q && !w1c[ST_MERR]);
    s_err_d = s_fail || (s_err_q && !w1c[ST_SERR]);
    m_cnt_d = clr ? '0 : m_cnt_q + AXI_DATA_WIDTH'(m_done);
    s_cnt_d = clr ? '0 : s_cnt_q + AXI_DATA_WIDTH'(s_done);
    err_d = clr ? 8'd0 : {s_fail ? s2mm_status_error : err_q[7:4], m_fail ? mm2s_status_error : err_q[3:0]};
    status = '0;
    status[ST_MEMPTY] = m_empty;
    status[ST_MFULL] = m_full;
    status[ST_SEMPTY] = s_empty;
    status[ST_SFULL] = s_full;
    status[ST_OVF] = ovf_q;
    status[ST_MERR] = m_err_q;
    status[ST_SERR] = s_err_q;
    status[ST_MLVL+:LVL_W] = m_lvl;
    status[ST_SLVL+:LVL_W] = s_lvl;
    rd_d = '0;
    case (reg_rd_addr)
      AXI_ADDR_WIDTH'(A_STATUS):     rd_d = status;
      AXI_ADDR_WIDTH'(A_MM2S_ADDR):  rd_d = m_addr_q;
      AXI_ADDR_WIDTH'(A_MM2S_BYTES): rd_d = m_bytes_q;
      AXI_ADDR_WIDTH'(A_MM2S_TUSER): rd_d = m_tuser_q;
      AXI_ADDR_WIDTH'(A_S2MM_ADDR):  rd_d = s_addr_q;
      AXI_ADDR_WIDTH'(A_S2MM_BYTES): rd_d = s_bytes_q;
      AXI_ADDR_WIDTH'(A_MM2S_DONE):  rd_d = m_cnt_q;
      AXI_ADDR_WIDTH'(A_S2MM_DONE):  rd_d = s_cnt_q;
      AXI_ADDR_WIDTH'(A_ERR):        rd_d = AXI_DATA_WIDTH'(err_q);
`ifdef DMA_QUEUE_IRQ_EN
      AXI_ADDR_WIDTH'(A_IRQ_PEND):   rd_d = AXI_DATA_WIDTH'(pend_q);
      AXI_ADDR_WIDTH'(A_IRQ_MASK):   rd_d = mask_q;
`endif
      default:                       rd_d = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_addr_q <= '0;
      m_bytes_q <= '0;
      m_tuser_q <= '0;
      s_addr_q <= '0;
      s_bytes_q <= '0;
      m_cnt_q <= '0;
      s_cnt_q <= '0;
      err_q <= '0;
      seq_q <= '0;
      ovf_q <= 1'b0;
      m_err_q <= 1'b0;
      s_err_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (wr_hit(A_MM2S_ADDR)) m_addr_q <= reg_wr_data;
      if (wr_hit(A_MM2S_BYTES)) m_bytes_q <= reg_wr_data;
      if (wr_hit(A_MM2S_TUSER)) m_tuser_q <= reg_wr_data;
      if (wr_hit(A_S2MM_ADDR)) s_addr_q <= reg_wr_data;
      if (wr_hit(A_S2MM_BYTES)) s_bytes_q <= reg_wr_data;
      m_cnt_q <= m_cnt_d;
      s_cnt_q <= s_cnt_d;
      err_q <= err_d;
      seq_q <= seq_q + AXI_TAG_WIDTH'(push_ok);
      ovf_q <= ovf_d;
      m_err_q <= m_err_d;
      s_err_q <= s_err_d;
      if (reg_rd_en) rd_data_q <= rd_d;
    end
  end
`ifdef DMA_QUEUE_IRQ_EN
  always_comb begin
    pend_d = pend_q & ~(wr_hit(A_IRQ_PEND) ? reg_wr_data[2:0] : 3'd0);
    pend_d[IRQ_MDONE] = pend_d[IRQ_MDONE] | m_done;
    pend_d[IRQ_SDONE] = pend_d[IRQ_SDONE] | s_done;
    pend_d[IRQ_ERR] = pend_d[IRQ_ERR] | m_fail | s_fail | ovf_ev;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (wr_hit(A_IRQ_MASK)) mask_q <= reg_wr_data;
      irq_q <= |(pend_q & mask_q[2:0]);
    end
  end
  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_dma_queue_controller.sv
// tb_dma_queue_controller: scoreboard bench with a queue-level reference model and randomized traffic
module tb_dma_queue_controller;
  localparam int Q = 4;
  typedef struct packed { logic [63:0] desc; logic [64:0] user; } ment_t;
  typedef struct packed { logic [63:0] desc; logic [7:0] tag; } sent_t;
  logic clk = 0, rstn = 0;
  logic reg_wr_en = 0, reg_rd_en = 0;
  logic [31:0] reg_wr_addr = 0, reg_rd_addr = 0, reg_wr_data = 0, reg_rd_data;
  logic [63:0] mm2s_desc, s2mm_desc;
  logic [64:0] mm2s_user;
  logic [7:0] s2mm_tag;
  logic mm2s_valid, s2mm_valid;
  logic mm2s_ready = 0, s2mm_ready = 0, mm2s_status_valid = 0, s2mm_status_valid = 0;
  logic [3:0] mm2s_status_error = 0, s2mm_status_error = 0;
`ifdef DMA_QUEUE_IRQ_EN
  logic irq;
  logic [2:0] pend = 0;
  logic [31:0] mask = 0;
  logic irq_e = 0;
`endif
  int checks = 0, failures = 0;
  ment_t mq[$];
  sent_t sq[$];
  logic [31:0] exp_rd[$];
  logic [31:0] stg [16];
  logic [31:0] mcnt = 0, scnt = 0;
  logic [7:0] err = 0, seq = 0;
  logic ovf = 0, merr = 0, serr = 0, rd_pend = 0;

  always #5 clk = ~clk;

  dma_queue_controller dut (
    .clk(clk), .rstn(rstn), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_wr_addr(reg_wr_addr), .reg_rd_addr(reg_rd_addr), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
    .mm2s_desc(mm2s_desc), .mm2s_user(mm2s_user), .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready),
    .mm2s_status_error(mm2s_status_error), .mm2s_status_valid(mm2s_status_valid),
    .s2mm_desc(s2mm_desc), .s2mm_tag(s2mm_tag), .s2mm_valid(s2mm_valid), .s2mm_ready(s2mm_ready),
    .s2mm_status_error(s2mm_status_error), .s2mm_status_valid(s2mm_status_valid)
`ifdef DMA_QUEUE_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] r;
    r = 0;
    case (a)
      1: r = {11'b0, 5'(sq.size()), 3'b0, 5'(mq.size()), 1'b0, serr, merr, ovf,
              sq.size() == Q, sq.size() == 0, mq.size() == Q, mq.size() == 0};
      2, 3, 4, 5, 6: r = stg[a[3:0]];
      7: r = mcnt;
      8: r = scnt;
      9: r = {24'b0, err};
`ifdef DMA_QUEUE_IRQ_EN
      10: r = {29'b0, pend};
      11: r = mask;
`endif
      default: r = 0;
    endcase
    return r;
  endfunction

  // One clock of the reference model: decide from pre-edge state, commit at the edge
  task automatic tick();
    logic wr_c, push, clr, acc, md, sd, mf, sf;
    logic [31:0] w1c;
    ment_t me;
    sent_t se;
`ifdef DMA_QUEUE_IRQ_EN
    logic [31:0] wp;
    logic irq_n;
    wp = (reg_wr_en && reg_wr_addr == 10) ? reg_wr_data : 0;
    irq_n = |(pend & mask[2:0]);
`endif
    wr_c = reg_wr_en && reg_wr_addr == 0;
    push = wr_c && reg_wr_data[0];
    clr = wr_c && reg_wr_data[1];
    acc = push && mq.size() < Q && sq.size() < Q;
    me = '{desc: {stg[3], stg[2]}, user: {33'b0, stg[4]}};
    se = '{desc: {stg[6], stg[5]}, tag: seq};
    w1c = (reg_wr_en && reg_wr_addr == 1) ? reg_wr_data : 0;
    md = mm2s_status_valid && mm2s_status_error == 0;
    mf = mm2s_status_valid && mm2s_status_error != 0;
    sd = s2mm_status_valid && s2mm_status_error == 0;
    sf = s2mm_status_valid && s2mm_status_error != 0;
    if (reg_rd_en) exp_rd.push_back(model_rd(reg_rd_addr));
    @(posedge clk);
    if (acc) begin
      mq.push_back(me);
      sq.push_back(se);
      seq++;
    end
    ovf = (push && !acc) || (ovf && !w1c[4]);
    merr = mf || (merr && !w1c[5]);
    serr = sf || (serr && !w1c[6]);
    mcnt = clr ? 0 : mcnt + 32'(md);
    scnt = clr ? 0 : scnt + 32'(sd);
    if (clr) err = 0;
    else begin
      if (mf) err[3:0] = mm2s_status_error;
      if (sf) err[7:4] = s2mm_status_error;
    end
`ifdef DMA_QUEUE_IRQ_EN
    pend = {mf || sf || (push && !acc), sd, md} | (pend & ~wp[2:0]);
    if (reg_wr_en && reg_wr_addr == 11) mask = reg_wr_data;
    irq_e = irq_n;
`endif
    if (reg_wr_en && reg_wr_addr >= 2 && reg_wr_addr <= 6) stg[reg_wr_addr[3:0]] = reg_wr_data;
    #1;
`ifdef DMA_QUEUE_IRQ_EN
    chk("irq", irq, irq_e);
`endif
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    reg_wr_en = 1; reg_wr_addr = a; reg_wr_data = d;
    tick();
    reg_wr_en = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    reg_rd_en = 1; reg_rd_addr = a;
    tick();
    reg_rd_en = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reg_wr_en = 0; reg_rd_en = 0; mm2s_ready = 0; s2mm_ready = 0;
    mm2s_status_valid = 0; s2mm_status_valid = 0;
    rstn = 0;
    mq.delete(); sq.delete(); exp_rd.delete();
    foreach (stg[i]) stg[i] = 0;
    mcnt = 0; scnt = 0; err = 0; seq = 0; ovf = 0; merr = 0; serr = 0;
`ifdef DMA_QUEUE_IRQ_EN
    pend = 0; mask = 0; irq_e = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mm2s_valid", mm2s_valid, 0);
    chk("rst_s2mm_valid", s2mm_valid, 0);
    chk("rst_rd_data", reg_rd_data, 0);
`ifdef DMA_QUEUE_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    rstn = 1;
  endtask

  // Monitor: compare queue heads against the scoreboard and retire on handshake
  always @(negedge clk) begin
    if (!rstn) rd_pend = 0;
    else begin
      chk("mm2s_valid", mm2s_valid, mq.size() != 0);
      if (mm2s_valid && mq.size() != 0) begin
        chk("mm2s_desc", mm2s_desc, mq[0].desc);
        chk("mm2s_user", mm2s_user, mq[0].user);
        if (mm2s_ready) void'(mq.pop_front());
      end
      chk("s2mm_valid", s2mm_valid, sq.size() != 0);
      if (s2mm_valid && sq.size() != 0) begin
        chk("s2mm_desc", s2mm_desc, sq[0].desc);
        chk("s2mm_tag", s2mm_tag, sq[0].tag);
        if (s2mm_ready) void'(sq.pop_front());
      end
      if (rd_pend) begin
        if (exp_rd.size() == 0) chk("rd_underflow", 1, 0);
        else chk("rd_data", reg_rd_data, exp_rd.pop_front());
      end
      rd_pend = reg_rd_en;
    end
  end

  initial begin
    foreach (stg[i]) stg[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mm2s_valid", mm2s_valid, 0);
    chk("rst_s2mm_valid", s2mm_valid, 0);
    chk("rst_rd_data", reg_rd_data, 0);
    rstn = 1;
    for (int a = 0; a < 13; a++) rd(a);
    wr(2, 32'h1000); wr(3, 64); wr(4, 32'hCAFE_0001); wr(5, 32'h2000); wr(6, 64);
    mm2s_ready = 1;
    wr(0, 1);
    idle(2);
    mm2s_ready = 0;
    mm2s_status_valid = 1; mm2s_status_error = 0;
    tick();
    mm2s_status_valid = 0;
    rd(7); rd(1);
    s2mm_ready = 1;
    idle(2);
    s2mm_ready = 0;
    for (int i = 0; i < Q + 1; i++) wr(0, 1);
    rd(1);
    wr(1, 32'h10);
    rd(1);
    do_reset();
    rd(1);
    wr(5, 32'h3000); wr(6, 32);
    for (int i = 0; i < 4; i++) begin
      s2mm_ready = ~s2mm_ready;
      wr(0, 1);
    end
    for (int i = 0; i < 8; i++) begin
      s2mm_ready = ~s2mm_ready;
      tick();
    end
    s2mm_ready = 0;
    s2mm_status_valid = 1; s2mm_status_error = 4'h3;
    tick();
    s2mm_status_valid = 0;
    rd(1); rd(9); rd(8);
    mm2s_status_valid = 1; mm2s_status_error = 0;
    tick();
    wr(0, 2);
    mm2s_status_valid = 0;
    rd(7); rd(9);
`ifdef DMA_QUEUE_IRQ_EN
    wr(10, 7);
    wr(11, 1);
    mm2s_status_valid = 1; mm2s_status_error = 0;
    tick();
    mm2s_status_valid = 0;
    tick();
    chk("irq_raised", irq, 1);
    wr(10, 1);
    tick();
    chk("irq_cleared", irq, 0);
    rd(10); rd(11);
`endif
    for (int i = 0; i < 600; i++) begin
      int op;
      mm2s_ready = 1'($urandom % 2);
      s2mm_ready = 1'($urandom % 2);
      mm2s_status_valid = ($urandom % 4) == 0;
      mm2s_status_error = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      s2mm_status_valid = ($urandom % 4) == 0;
      s2mm_status_error = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      reg_rd_en = 1'($urandom % 2);
      reg_rd_addr = $urandom % 14;
      reg_wr_en = 1;
      op = $urandom % 10;
      if (op < 3) begin reg_wr_addr = 0; reg_wr_data = ($urandom % 8 == 0) ? 3 : 1; end
      else if (op < 5) begin reg_wr_addr = $urandom_range(2, 6); reg_wr_data = $urandom; end
      else if (op == 5) begin reg_wr_addr = 1; reg_wr_data = $urandom; end
      else if (op == 6) begin reg_wr_addr = $urandom % 16; reg_wr_data = $urandom; end
      else reg_wr_en = 0;
      tick();
    end
    reg_wr_en = 0; reg_rd_en = 0;
    mm2s_status_valid = 0; s2mm_status_valid = 0;
    mm2s_ready = 1; s2mm_ready = 1;
    idle(2 * Q + 2);
    for (int a = 0; a < 13; a++) rd(a);
    idle(3);
    chk("rd_drained", exp_rd.size(), 0);
    chk("mm2s_drained", mq.size(), 0);
    chk("s2mm_drained", sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_queue_controller.md
Name: dma_queue_controller

Overview:
- Register-mapped DMA descriptor controller with per-direction descriptor queues, QDEPTH entries each.
- Software stages MM2S/S2MM descriptors and pushes them as a pair.
- MM2S and S2MM heads issue independently to the datamovers. Completions are counted, and errors are latched sticky.
- Sits between the PS register bridge and the AXI datamover command/status ports; successor to the single-shot start/done controller.

Parameters:
- AXI_ADDR_WIDTH, 32, descriptor address width.
- AXI_DATA_WIDTH, 32, register data width (must be >= 32).
- AXI_LEN_WIDTH, 32, descriptor byte-count width.
- AXI_TAG_WIDTH, 8, S2MM tag width.
- AXIS_USER_WIDTH, 65, MM2S user width; zero-extended or truncated from the TUSER register.
- QDEPTH, 4, queue depth per direction; power of 2, range 2..16.
- Derived localparams: DESC_WIDTH = AXI_ADDR_WIDTH + AXI_LEN_WIDTH; LVL_W = $clog2(QDEPTH) + 1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- reg_wr_en, reg_rd_en  in  1  register write/read strobes
- reg_wr_addr, reg_rd_addr  in  AXI_ADDR_WIDTH  word addresses
- reg_wr_data  in  AXI_DATA_WIDTH  write data
- reg_rd_data  out  AXI_DATA_WIDTH  read data, 1-cycle latency
- mm2s_desc  out  DESC_WIDTH  {len, addr} at MM2S queue head
- mm2s_user  out  AXIS_USER_WIDTH  user field at MM2S queue head
- mm2s_valid  out  1  MM2S queue not empty
- mm2s_ready  in  1  MM2S datamover accepts the command
- mm2s_status_error  in  4  MM2S status error code
- mm2s_status_valid  in  1  MM2S status strobe
- s2mm_desc  out  DESC_WIDTH  {len, addr} at S2MM queue head
- s2mm_tag  out  AXI_TAG_WIDTH  tag at S2MM queue head
- s2mm_valid  out  1  S2MM queue not empty
- s2mm_ready  in  1  S2MM datamover accepts the command
- s2mm_status_error  in  4  S2MM status error code
- s2mm_status_valid  in  1  S2MM status strobe

Behaviour:
- Reset: all registers, queues, counters and reg_rd_data are 0; both valids are 0.
- Register map (word address):
  - 0 CTRL (WO, self-clear). bit0 PUSH; bit1 CLR_CNT.
  - 1 STATUS (RO except W1C bits):
    - [0] mm2s_empty, [1] mm2s_full, [2] s2mm_empty, [3] s2mm_full.
    - [4] overflow, [5] mm2s_err, [6] s2mm_err: sticky, W1C.
    - [8+:LVL_W] mm2s_level, [16+:LVL_W] s2mm_level.
  - 2 MM2S_ADDR, 3 MM2S_BYTES, 4 MM2S_TUSER, 5 S2MM_ADDR, 6 S2MM_BYTES: RW staging registers.
  - 7 MM2S_DONE_CNT, 8 S2MM_DONE_CNT (RO): wrap at 2^AXI_DATA_WIDTH.
  - 9 ERR (RO): [3:0] last MM2S error code, [7:4] last S2MM error code.
  - Reads of unmapped addresses return 0. Writes to RO or unmapped addresses are ignored.
- PUSH:
  - If neither queue is full (evaluated on pre-cycle state), both queues push in the same cycle.
  - The MM2S entry carries MM2S_ADDR, MM2S_BYTES and MM2S_TUSER. The S2MM entry carries S2MM_ADDR, S2MM_BYTES and tag = seq.
  - seq is an AXI_TAG_WIDTH counter that increments per accepted push and wraps.
  - If either queue is full, nothing is pushed and overflow is set. A pop in the same cycle does not free space for that push.
- Issue:
  - valid = !empty. Desc/user/tag come from the queue head and are stable while valid && !ready.
  - The head pops on valid && ready. The two directions are fully decoupled.
- Status:
  - status_valid with error == 0 increments that direction's DONE_CNT.
  - status_valid with error != 0 sets the sticky err bit and captures the code in ERR; the counter is unchanged.
- CLR_CNT zeroes both DONE_CNTs and ERR; it wins over a same-cycle completion.
- Same-cycle W1C and a set event on the same bit: set wins.
- Same-cycle PUSH and pop on a non-full queue: level is unchanged, and head/tail both advance correctly.
- A register write to a staging register in the same cycle as PUSH pushes the old staging value.
- Reset asserted mid-operation flushes the queues; in-flight datamover status after reset is counted normally.

Optional Feature:
- Macro DMA_QUEUE_IRQ_EN.
- With it:
  - Adds output port irq (1 bit).
  - Register 10 IRQ_PEND (W1C), with bits [0] mm2s_done, [1] s2mm_done, [2] any error or overflow.
  - Register 11 IRQ_MASK (RW).
  - irq is registered: irq <= |(IRQ_PEND & IRQ_MASK), so it asserts 1 cycle after the pending bit sets.
- Without it: no irq port; addresses 10 and 11 read 0.

Decomposition:
- Package dma_queue_pkg holds the register address localparams, STATUS/CTRL bit indices and the IRQ bit indices.
- Sub-module dma_desc_fifo: synchronous FIFO with parameters WIDTH and DEPTH; outputs full, empty and level; supports simultaneous push and pop. It is instantiated twice.

Test Plan:
- Reset, then read all registers: STATUS = 0x5 (both queues empty), all others 0; both valids are 0.
- Stage MM2S addr 0x1000/len 64 and S2MM addr 0x2000/len 64, then PUSH with mm2s_ready = 1:
  - mm2s_desc = {64, 0x1000} pops after 1 cycle.
  - s2mm_tag = 0.
  - One mm2s_status_valid with error 0 gives MM2S_DONE_CNT = 1.
- Hold both readies at 0 and PUSH QDEPTH + 1 times: full bits set, overflow = 1, level = QDEPTH. W1C bit4 clears overflow.
- Four pushes with s2mm_ready toggling every cycle: four S2MM issues in push order with tags 0..3; desc is held stable while ready = 0.
- s2mm_status_valid with error 0x3: s2mm_err = 1, ERR[7:4] = 3, S2MM_DONE_CNT unchanged. A completion in the same cycle as CLR_CNT leaves DONE_CNT = 0.
- With DMA_QUEUE_IRQ_EN: IRQ_MASK = 1 and an MM2S completion raise irq the next cycle; W1C of IRQ_PEND bit0 deasserts irq one cycle later.
